wgt_bank_ring: RTL and testbench

Weight buffer with NBANKS ring-ordered banks, generalising the two-bank ping/pong scheme. Sits between the host/DMA weight loader and the systolic array. The loader fills and commits whole tiles while the array consumes earlier tiles. Per-bank ownership, tile length, 2-cycle registered reads with valid, and error flagging replace software-managed bank selects.

---
 rtl/wgt_bank_ring.sv | 111 +++++++++++
 tb/tb_wgt_bank_ring.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/wgt_bank_ring.sv
// Ring of NBANKS weight banks: the loader fills and commits tiles while the array reads earlier ones.
// Reads use a two-stage registered pipeline with a valid flag. Protocol misuse sets a sticky error flag.
module wgt_bank_ring #(
  parameter int unsigned TN         = 128,
  parameter int unsigned ADDR_WIDTH = 7,
  parameter int unsigned NBANKS     = 4,
  localparam int unsigned BW        = $clog2(NBANKS)
) (
  input  logic                  clk,
  input  logic                  rst,
  output logic                  wr_ready,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] waddr,
  input  logic [TN*8-1:0]       wdata,
  input  logic [TN-1:0]         wstrb,
  input  logic                  wr_commit,
  input  logic [ADDR_WIDTH:0]   wr_len,
  output logic                  rd_avail,
  output logic [ADDR_WIDTH:0]   rd_len,
  input  logic                  rd_en,
  input  logic [ADDR_WIDTH-1:0] k_idx,
  input  logic                  rd_release,
  output logic [TN*8-1:0]       b_vec,
  output logic                  b_valid,
  output logic [BW-1:0]         wr_bank,
  output logic [BW-1:0]         rd_bank,
  output logic [BW:0]           bank_count,
  output logic                  err
);

  localparam int unsigned W     = TN * 8;
  localparam int unsigned DEPTH = 1 << ADDR_WIDTH;
  localparam int unsigned LW    = ADDR_WIDTH + 1;
  localparam int unsigned CW    = BW + 1;

  logic [W-1:0]  mem [NBANKS*DEPTH];
  logic [LW-1:0] len [NBANKS];
  logic [LW-1:0] len_nxt [NBANKS];

  logic [BW-1:0] wr_ptr, rd_ptr, wr_ptr_nxt, rd_ptr_nxt;
  logic [CW-1:0] count, count_nxt;
  logic          s1_valid;
  logic [W-1:0]  s1_data;

  logic wr_acc, len_ok, rel_acc, commit_acc, rd_acc, rd_oob, err_set;

  assign wr_bank    = wr_ptr;
  assign rd_bank    = rd_ptr;
  assign bank_count = count;

  // Acceptance and next-state; a commit into a full ring is allowed when the head is released at the same edge.
  always_comb begin
    wr_acc     = we && wr_ready;
    len_ok     = (wr_len != '0) && (wr_len <= LW'(DEPTH));
    rel_acc    = rd_release && rd_avail;
    commit_acc = wr_commit && len_ok && (wr_ready || rel_acc);
    rd_acc     = rd_en && rd_avail;
    rd_oob     = rd_acc && (LW'(k_idx) >= len[rd_ptr]);
    err_set    = (we && !wr_ready) || (wr_commit && !commit_acc) ||
                 (rd_en && !rd_avail) || rd_oob || (rd_release && !rd_avail);

    wr_ptr_nxt = commit_acc ? wr_ptr + BW'(1) : wr_ptr;
    rd_ptr_nxt = rel_acc ? rd_ptr + BW'(1) : rd_ptr;
    count_nxt  = count + CW'(commit_acc) - CW'(rel_acc);

    len_nxt = len;
    if (rel_acc) len_nxt[rd_ptr] = '0;
    if (commit_acc) len_nxt[wr_ptr] = wr_len;
  end

  // Control state, status outputs and read pipeline.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      for (int i = 0; i < NBANKS; i++) len[i] <= '0;
      wr_ready <= 1'b1;
      rd_avail <= 1'b0;
      rd_len   <= '0;
      s1_valid <= 1'b0;
      s1_data  <= '0;
      b_valid  <= 1'b0;
      b_vec    <= '0;
      err      <= 1'b0;
    end else begin
      wr_ptr   <= wr_ptr_nxt;
      rd_ptr   <= rd_ptr_nxt;
      count    <= count_nxt;
      len      <= len_nxt;
      wr_ready <= count_nxt < CW'(NBANKS);
      rd_avail <= count_nxt != '0;
      rd_len   <= len_nxt[rd_ptr_nxt];
      s1_valid <= rd_acc;
      if (rd_acc) s1_data <= rd_oob ? '0 : mem[{rd_ptr, k_idx}];
      b_valid  <= s1_valid;
      if (s1_valid) b_vec <= s1_data;
      if (err_set) err <= 1'b1;
    end
  end

  // Byte-masked row write into the fill bank; storage is never cleared.
  always_ff @(posedge clk) begin
    if (!rst && wr_acc) begin
      for (int e = 0; e < TN; e++) begin
        if (wstrb[e]) mem[{wr_ptr, waddr}][8*e +: 8] <= wdata[8*e +: 8];
      end
    end
  end

endmodule

// File: tb/tb_wgt_bank_ring.sv
// Bench for wgt_bank_ring: directed scenarios plus random traffic against a tile-queue reference model.
module tb_wgt_bank_ring;

  localparam int unsigned TN    = 32;
  localparam int unsigned AW    = 4;
  localparam int unsigned NB    = 4;
  localparam int unsigned BW    = $clog2(NB);
  localparam int unsigned W     = TN * 8;
  localparam int unsigned DEPTH = 1 << AW;

  logic          clk = 1'b0;
  logic          rst;
  logic          wr_ready, we, wr_commit, rd_avail, rd_en, rd_release, b_valid, err;
  logic [AW-1:0] waddr, k_idx;
  logic [W-1:0]  wdata, b_vec;
  logic [TN-1:0] wstrb;
  logic [AW:0]   wr_len, rd_len;
  logic [BW-1:0] wr_bank, rd_bank;
  logic [BW:0]   bank_count;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: storage, FIFO of committed tiles (bank, length), fill bank, read pipeline.
  logic [W-1:0] mm [NB][DEPTH];
  int           qb[$];
  int           ql[$];
  int           m_wr_b;
  logic         m_err, m_s1_v, m_bv;
  logic [W-1:0] m_s1_d, m_bvec;

  wgt_bank_ring #(.TN(TN), .ADDR_WIDTH(AW), .NBANKS(NB)) dut (
    .clk(clk), .rst(rst), .wr_ready(wr_ready), .we(we), .waddr(waddr), .wdata(wdata),
    .wstrb(wstrb), .wr_commit(wr_commit), .wr_len(wr_len), .rd_avail(rd_avail),
    .rd_len(rd_len), .rd_en(rd_en), .k_idx(k_idx), .rd_release(rd_release),
    .b_vec(b_vec), .b_valid(b_valid), .wr_bank(wr_bank), .rd_bank(rd_bank),
    .bank_count(bank_count), .err(err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [W-1:0] rep(input logic [7:0] b);
    return {TN{b}};
  endfunction

  task automatic idle();
    we = 1'b0; waddr = '0; wdata = '0; wstrb = '0; wr_commit = 1'b0; wr_len = '0;
    rd_en = 1'b0; k_idx = '0; rd_release = 1'b0;
  endtask

  // Advance the model by one clock from the current inputs, clock the DUT, compare every output.
  task automatic cycle();
    int n;
    logic wr_rdy, rd_av, rel_ok, com_ok, len_ok;
    logic [W-1:0] row;
    n = qb.size();
    wr_rdy = (n < NB);
    rd_av  = (n > 0);
    if (rst) begin
      qb.delete(); ql.delete();
      m_wr_b = 0; m_err = 1'b0; m_s1_v = 1'b0; m_bv = 1'b0; m_bvec = '0; m_s1_d = '0;
    end else begin
      if (m_s1_v) m_bvec = m_s1_d;
      m_bv = m_s1_v;
      m_s1_v = rd_en && rd_av;
      if (rd_en && rd_av) begin
        if (int'(k_idx) < ql[0]) m_s1_d = mm[qb[0]][k_idx];
        else begin
          m_s1_d = '0;
          m_err = 1'b1;
        end
      end
      if (rd_en && !rd_av) m_err = 1'b1;
      if (we) begin
        if (wr_rdy) begin
          row = mm[m_wr_b][waddr];
          for (int e = 0; e < TN; e++) if (wstrb[e]) row[8*e +: 8] = wdata[8*e +: 8];
          mm[m_wr_b][waddr] = row;
        end else m_err = 1'b1;
      end
      len_ok = (int'(wr_len) >= 1) && (int'(wr_len) <= DEPTH);
      rel_ok = rd_release && rd_av;
      com_ok = wr_commit && len_ok && (wr_rdy || rel_ok);
      if (wr_commit && !com_ok) m_err = 1'b1;
      if (rd_release && !rd_av) m_err = 1'b1;
      if (rel_ok) begin
        void'(qb.pop_front());
        void'(ql.pop_front());
      end
      if (com_ok) begin
        qb.push_back(m_wr_b);
        ql.push_back(int'(wr_len));
        m_wr_b = (m_wr_b + 1) % NB;
      end
    end
    @(posedge clk);
    #1;
    n = qb.size();
    check("wr_ready",   W'(wr_ready),   W'(n < NB));
    check("rd_avail",   W'(rd_avail),   W'(n > 0));
    check("rd_len",     W'(rd_len),     W'(n > 0 ? ql[0] : 0));
    check("wr_bank",    W'(wr_bank),    W'(m_wr_b));
    check("rd_bank",    W'(rd_bank),    W'(n > 0 ? qb[0] : m_wr_b));
    check("bank_count", W'(bank_count), W'(n));
    check("b_valid",    W'(b_valid),    W'(m_bv));
    check("b_vec",      b_vec,          m_bvec);
    check("err",        W'(err),        W'(m_err));
  endtask

  task automatic do_reset();
    idle();
    rst = 1'b1;
    cycle();
    cycle();
    rst = 1'b0;
  endtask

  initial begin
    logic [W-1:0] expv;
    for (int b = 0; b < NB; b++) for (int r = 0; r < DEPTH; r++) mm[b][r] = '0;
    rst = 1'b1;
    idle();
    do_reset();
    check("rst_wr_ready", W'(wr_ready), W'(1));
    check("rst_b_vec", b_vec, '0);

    // Initialise every row of every bank so all later reads are defined.
    for (int b = 0; b < NB; b++) begin
      for (int r = 0; r < DEPTH; r++) begin
        we = 1'b1; waddr = AW'(r); wstrb = '1;
        for (int j = 0; j < W / 32; j++) wdata[32*j +: 32] = $urandom;
        cycle();
      end
      idle(); wr_commit = 1'b1; wr_len = (AW+1)'(DEPTH); cycle();
      idle(); rd_release = 1'b1; cycle();
      idle();
    end

    // Fill rows 0..3 with r+1, commit 4, read back-to-back.
    do_reset();
    for (int r = 0; r < 4; r++) begin
      we = 1'b1; waddr = AW'(r); wdata = rep(8'(r + 1)); wstrb = '1;
      cycle();
    end
    idle(); wr_commit = 1'b1; wr_len = 5'd4; cycle(); idle();
    check("seq_rd_len", W'(rd_len), W'(4));
    for (int i = 0; i < 6; i++) begin
      idle();
      if (i < 4) begin rd_en = 1'b1; k_idx = AW'(i); end
      cycle();
      check("seq_b_valid", W'(b_valid), W'(i >= 1 && i <= 4));
      if (i >= 1 && i <= 4) check("seq_b_vec", b_vec, rep(8'(i)));
    end

    // Fill the ring, overflow write, release, then commit and release together on a full ring.
    do_reset();
    for (int t = 0; t < NB; t++) begin
      idle(); wr_commit = 1'b1; wr_len = 5'd1; cycle();
    end
    idle();
    check("full_count", W'(bank_count), W'(NB));
    check("full_wr_ready", W'(wr_ready), W'(0));
    we = 1'b1; waddr = '0; wdata = '1; wstrb = '1; cycle(); idle();
    check("full_we_err", W'(err), W'(1));
    rd_release = 1'b1; cycle(); idle();
    check("rel_wr_ready", W'(wr_ready), W'(1));
    check("rel_wr_bank", W'(wr_bank), W'(0));
    wr_commit = 1'b1; wr_len = 5'd2; cycle(); idle();
    wr_commit = 1'b1; wr_len = 5'd3; rd_release = 1'b1; cycle(); idle();
    check("both_count", W'(bank_count), W'(NB));
    check("both_wr_bank", W'(wr_bank), W'(2));
    check("both_rd_bank", W'(rd_bank), W'(2));

    // Byte strobes over a row of 0xAA.
    do_reset();
    we = 1'b1; waddr = 4'd0; wdata = rep(8'hAA); wstrb = '1; cycle();
    wdata = rep(8'h11); wstrb = {(TN/2){2'b01}}; cycle(); idle();
    wr_commit = 1'b1; wr_len = 5'd4; cycle(); idle();
    rd_en = 1'b1; k_idx = 4'd0; cycle(); idle(); cycle();
    for (int e = 0; e < TN; e++) expv[8*e +: 8] = (e % 2 == 0) ? 8'h11 : 8'hAA;
    check("strb_b_vec", b_vec, expv);
    check("strb_err", W'(err), W'(0));

    // Out-of-range row, then read on an empty ring.
    rd_en = 1'b1; k_idx = 4'd5; cycle(); idle(); cycle();
    check("oob_b_valid", W'(b_valid), W'(1));
    check("oob_b_vec", b_vec, '0);
    check("oob_err", W'(err), W'(1));
    rd_release = 1'b1; cycle(); idle();
    rd_en = 1'b1; k_idx = 4'd0; cycle(); idle(); cycle();
    check("empty_b_valid", W'(b_valid), W'(0));

    // Reset while a read is in flight.
    do_reset();
    wr_commit = 1'b1; wr_len = 5'd2; cycle(); idle();
    rd_en = 1'b1; k_idx = 4'd1; cycle(); idle();
    rst = 1'b1; cycle(); rst = 1'b0;
    check("rstfl_b_valid", W'(b_valid), W'(0));
    cycle();
    check("rstfl_b_valid2", W'(b_valid), W'(0));
    check("rstfl_count", W'(bank_count), W'(0));
    check("rstfl_err", W'(err), W'(0));

    // Random traffic.
    for (int c = 0; c < 3000; c++) begin
      idle();
      rst = ($urandom_range(0, 199) == 0);
      we = $urandom_range(0, 1) == 1;
      waddr = AW'($urandom);
      for (int j = 0; j < W / 32; j++) wdata[32*j +: 32] = $urandom;
      wstrb = ($urandom_range(0, 2) == 0) ? '1 : TN'($urandom);
      wr_commit = ($urandom_range(0, 6) == 0);
      wr_len = ($urandom_range(0, 9) == 0) ? (AW+1)'($urandom) : (AW+1)'($urandom_range(1, DEPTH));
      rd_en = $urandom_range(0, 1) == 1;
      k_idx = AW'($urandom);
      rd_release = ($urandom_range(0, 6) == 0);
      cycle();
    end
    rst = 1'b0;
    idle();
    cycle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
